booth_mul_pipe: RTL and testbench

BOOTH_MUL_PIPE -- requirements
Module: booth_mul_pipe

---
 rtl/booth_mul_pkg.sv | 31 +++
 rtl/booth_csa_tree.sv | 47 ++++
 rtl/booth_mul_pipe.sv | 121 ++++++++++++
 tb/tb_booth_mul_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: digit select encoding,
// digit count and the recoding function used by stage 1.
package booth_mul_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  // One digit per bit pair plus a top digit that absorbs the extension bits.
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}; digit = -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic booth_sel_e booth_encode(input logic [2:0] trip);
    booth_sel_e sel;
    case (trip)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_csa_tree.sv
// Purely combinational carry-save reduction of ROWS equal-width rows down to
// a sum/carry pair, built as successive levels of 3:2 compressors.
module booth_csa_tree #(
  parameter int ROWS = 17,
  parameter int W    = 64
) (
  input  logic [W-1:0] rows_i [ROWS],
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] work [ROWS];
  logic [W-1:0] nxt  [ROWS];
  int           cnt;
  int           grp;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    work = rows_i;
    nxt  = rows_i;
    cnt  = ROWS;
    grp  = 0;
    // Each level turns every full group of three rows into two; leftovers pass through.
    for (int lvl = 0; lvl < ROWS; lvl++) begin
      if (cnt > 2) begin
        grp = cnt / 3;
        nxt = work;
        for (int g = 0; g < ROWS / 3; g++) begin
          if (g < grp) begin
            nxt[2*g]   = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
            nxt[2*g+1] = ((work[3*g] & work[3*g+1]) |
                          (work[3*g] & work[3*g+2]) |
                          (work[3*g+1] & work[3*g+2])) << 1;
          end
        end
        for (int r = 0; r < ROWS; r++) begin
          if (r >= 3 * grp && r < cnt) nxt[r-grp] = work[r];
        end
        cnt  = cnt - grp;
        work = nxt;
      end
    end
    sum_o   = work[0];
    carry_o = work[1];
  end

endmodule

// File: rtl/booth_mul_pipe.sv
// Three-stage radix-4 Booth multiplier with valid/ready handshake and tag sideband.
// Define BOOTH_MUL_SIGNED_EN to add the in_signed port for two's complement operands.
module booth_mul_pipe
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef BOOTH_MUL_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NDIG = booth_digits(WIDTH);
  localparam int PW   = 2 * WIDTH;

  logic             advance;
  logic             signed_op;
  logic [WIDTH+2:0] b_x;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    row;
  logic [PW-1:0]    pp_d [NDIG];
  logic [PW-1:0]    pp_q [NDIG];
  logic [PW-1:0]    csa_sum, csa_carry;
  logic [PW-1:0]    sum_d, sum_q, carry_d, carry_q, p_d, p_q;
  logic             v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [TAG_W-1:0] tag1_d, tag1_q, tag2_d, tag2_q, tag3_d, tag3_q;

  // The whole pipe moves as one; any free slot at the output lets it advance.
  assign advance  = !v3_q || out_ready;
  assign in_ready = advance;

`ifdef BOOTH_MUL_SIGNED_EN
  assign signed_op = in_signed;
`else
  assign signed_op = 1'b0;
`endif

  // Stage 1: recode in_b and form shifted, sign-handled partial product rows.
  always_comb begin
    b_x   = {{2{signed_op & in_b[WIDTH-1]}}, in_b, 1'b0};
    a_ext = {{WIDTH{signed_op & in_a[WIDTH-1]}}, in_a};
    row   = '0;
    for (int i = 0; i < NDIG; i++) begin
      unique case (booth_encode(b_x[2*i +: 3]))
        POS1:    row = a_ext;
        POS2:    row = a_ext << 1;
        NEG1:    row = -a_ext;
        NEG2:    row = -(a_ext << 1);
        default: row = '0;
      endcase
      pp_d[i] = advance ? (row << (2 * i)) : pp_q[i];
    end
  end

  booth_csa_tree #(
    .ROWS(NDIG),
    .W   (PW)
  ) u_csa (
    .rows_i (pp_q),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  always_comb begin
    v1_d    = advance ? in_valid : v1_q;
    tag1_d  = advance ? in_tag : tag1_q;
    v2_d    = advance ? v1_q : v2_q;
    tag2_d  = advance ? tag1_q : tag2_q;
    sum_d   = advance ? csa_sum : sum_q;
    carry_d = advance ? csa_carry : carry_q;
    v3_d    = advance ? v2_q : v3_q;
    // Only real results update the output registers, so bubbles leave out_p untouched.
    tag3_d  = (advance && v2_q) ? tag2_q : tag3_q;
    p_d     = (advance && v2_q) ? (sum_q + carry_q) : p_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      p_q    <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
      p_q    <= p_d;
    end
  end

  // NOTE: wide datapath registers carry no reset; the stage valids alone qualify them.
  always_ff @(posedge clk) begin
    pp_q    <= pp_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end

  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Self-checking bench: a 32-bit instance for directed scenarios and an 8-bit
// instance for a randomized run against an arithmetic reference model.
module tb_booth_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_a, w_in_b;
  logic [3:0]  w_in_tag, w_out_tag;
  logic [63:0] w_out_p;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0]  n_in_a, n_in_b;
  logic [3:0]  n_in_tag, n_out_tag;
  logic [15:0] n_out_p;

`ifdef BOOTH_MUL_SIGNED_EN
  logic w_in_signed, n_in_signed;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  booth_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .in_a     (w_in_a),
    .in_b     (w_in_b),
    .in_tag   (w_in_tag),
`ifdef BOOTH_MUL_SIGNED_EN
    .in_signed(w_in_signed),
`endif
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .out_p    (w_out_p),
    .out_tag  (w_out_tag)
  );

  booth_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (n_in_valid),
    .in_ready (n_in_ready),
    .in_a     (n_in_a),
    .in_b     (n_in_b),
    .in_tag   (n_in_tag),
`ifdef BOOTH_MUL_SIGNED_EN
    .in_signed(n_in_signed),
`endif
    .out_valid(n_out_valid),
    .out_ready(n_out_ready),
    .out_p    (n_out_p),
    .out_tag  (n_out_tag)
  );

  // Reference: extend operands to the product width, then multiply modulo 2^(2W).
  function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b,
                                           input logic sgn);
    logic [15:0] ea, eb;
    ea = sgn ? {{8{a[7]}}, a} : {8'd0, a};
    eb = sgn ? {{8{b[7]}}, b} : {8'd0, b};
    return ea * eb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_tag = '0; w_out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_a = '0; n_in_b = '0; n_in_tag = '0; n_out_ready = 1'b1;
`ifdef BOOTH_MUL_SIGNED_EN
    w_in_signed = 1'b0; n_in_signed = 1'b0;
`endif
    tick();
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", w_out_valid);
    end
    tests_run++;
    if (w_out_p !== 64'd0) begin
      tests_failed++; $display("FAIL reset_out_p: got %h expected 0", w_out_p);
    end
    tests_run++;
    if (w_out_tag !== 4'd0) begin
      tests_failed++; $display("FAIL reset_out_tag: got %0d expected 0", w_out_tag);
    end
    tests_run++;
    if (w_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %0b/%0b expected 1/1", w_in_ready, n_in_ready);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_cycle: in_ready %0b out_valid %0b expected 1 and 0", w_in_ready, w_out_valid);
    end
  endtask

  task automatic test_max_operands();
    w_in_valid = 1'b1; w_in_a = 32'hFFFF_FFFF; w_in_b = 32'hFFFF_FFFF; w_in_tag = 4'd3;
    w_out_ready = 1'b1;
    tick();
    w_in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      tests_run++;
      if (w_out_valid !== (k == 3)) begin
        tests_failed++;
        $display("FAIL latency_edge%0d: out_valid %0b expected %0b", k, w_out_valid, (k == 3));
      end
    end
    tests_run++;
    if (w_out_p !== 64'hFFFF_FFFE_0000_0001 || w_out_tag !== 4'd3) begin
      tests_failed++;
      $display("FAIL max_product: got %h tag %0d expected fffffffe00000001 tag 3", w_out_p, w_out_tag);
    end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL max_drain: out_valid %0b expected 0", w_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [63:0] e_v [3];
    a_v = '{32'd7, 32'd0, 32'd1};
    b_v = '{32'd6, $urandom, 32'h8000_0000};
    e_v = '{64'd42, 64'd0, 64'h8000_0000};
    w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_in_valid = 1'b1; w_in_a = a_v[i]; w_in_b = b_v[i]; w_in_tag = 4'(i + 5);
      tick();
    end
    w_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      tests_run++;
      if (w_out_valid !== 1'b1 || w_out_p !== e_v[i] || w_out_tag !== 4'(i + 5)) begin
        tests_failed++;
        $display("FAIL b2b_result%0d: valid %0b p %h tag %0d expected 1 %h %0d",
                 i, w_out_valid, w_out_p, w_out_tag, e_v[i], i + 5);
      end
    end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_tail: out_valid %0b expected 0", w_out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    logic [63:0] held_p;
    logic [3:0]  held_tag;
    logic        have_hold, fire_in, fire_out;
    int          idx, got;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = $urandom; b_v[i] = $urandom;
    end
    idx = 0; got = 0; have_hold = 1'b0; held_p = '0; held_tag = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      w_in_valid  = (idx < 4);
      w_in_a      = (idx < 4) ? a_v[idx] : 32'd0;
      w_in_b      = (idx < 4) ? b_v[idx] : 32'd0;
      w_in_tag    = 4'(idx + 8);
      w_out_ready = (cyc >= 5);
      #1;
      if (cyc == 3 || cyc == 4) begin
        tests_run++;
        if (w_in_ready !== 1'b0) begin
          tests_failed++; $display("FAIL stall_in_ready_c%0d: got %0b expected 0", cyc, w_in_ready);
        end
      end
      if (have_hold) begin
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_p !== held_p || w_out_tag !== held_tag) begin
          tests_failed++;
          $display("FAIL stall_stable_c%0d: valid %0b p %h tag %0d expected 1 %h %0d",
                   cyc, w_out_valid, w_out_p, w_out_tag, held_p, held_tag);
        end
      end
      have_hold = w_out_valid && !w_out_ready;
      held_p    = w_out_p;
      held_tag  = w_out_tag;
      fire_in   = w_in_valid && w_in_ready;
      fire_out  = w_out_valid && w_out_ready;
      if (fire_out) begin
        tests_run++;
        if (got >= 4) begin
          tests_failed++; $display("FAIL stall_extra: unexpected result %h expected none", w_out_p);
        end else if (w_out_p !== ref_mul32(a_v[got], b_v[got], 1'b0) || w_out_tag !== 4'(got + 8)) begin
          tests_failed++;
          $display("FAIL stall_order%0d: got %h tag %0d expected %h tag %0d", got, w_out_p,
                   w_out_tag, ref_mul32(a_v[got], b_v[got], 1'b0), got + 8);
        end
        got++;
      end
      @(posedge clk);
      if (fire_in) idx++;
      #1;
    end
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    tests_run++;
    if (got != 4 || idx != 4) begin
      tests_failed++; $display("FAIL stall_count: got %0d results %0d accepted expected 4 and 4", got, idx);
    end
  endtask

  task automatic test_reset_in_flight();
    w_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_in_valid = 1'b1; w_in_a = $urandom; w_in_b = $urandom; w_in_tag = 4'(i + 1);
      tick();
    end
    w_in_valid = 1'b0;
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL inflight_setup: out_valid %0b expected 1", w_out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (w_out_valid !== 1'b0 || w_out_p !== 64'd0 || w_out_tag !== 4'd0 || w_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL inflight_async_clear: valid %0b p %h tag %0d in_ready %0b expected 0 0 0 1",
               w_out_valid, w_out_p, w_out_tag, w_in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    w_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if (w_out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL inflight_ghost_c%0d: out_valid %0b expected 0", c, w_out_valid);
      end
    end
  endtask

`ifdef BOOTH_MUL_SIGNED_EN
  task automatic test_signed();
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_a = 32'hFFFF_FFFD; w_in_b = 32'd5; w_in_tag = 4'd1; w_in_signed = 1'b1;
    tick();
    w_in_tag = 4'd2; w_in_signed = 1'b0;
    tick();
    w_in_valid = 1'b0; w_in_signed = 1'b0;
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1 || w_out_p !== 64'hFFFF_FFFF_FFFF_FFF1 || w_out_tag !== 4'd1) begin
      tests_failed++;
      $display("FAIL signed_neg3x5: valid %0b p %h tag %0d expected 1 fffffffffffffff1 1",
               w_out_valid, w_out_p, w_out_tag);
    end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1 || w_out_p !== 64'h0000_0004_FFFF_FFF1 || w_out_tag !== 4'd2) begin
      tests_failed++;
      $display("FAIL unsigned_same_bits: valid %0b p %h tag %0d expected 1 4fffffff1 2",
               w_out_valid, w_out_p, w_out_tag);
    end
    tick();
  endtask
`endif

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  tag;
  } exp_t;

  task automatic test_random8();
    exp_t        q [$];
    exp_t        e;
    logic        hold_in, have_hold, fire_in, fire_out, sgn;
    logic [15:0] held_p;
    logic [3:0]  held_tag;
    int          sent, cyc;
    sent = 0; cyc = 0; hold_in = 1'b0; have_hold = 1'b0; held_p = '0; held_tag = '0; sgn = 1'b0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      if (!hold_in) begin
        n_in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        n_in_a     = 8'($urandom);
        n_in_b     = 8'($urandom);
        n_in_tag   = 4'($urandom);
`ifdef BOOTH_MUL_SIGNED_EN
        n_in_signed = 1'($urandom);
`endif
      end
`ifdef BOOTH_MUL_SIGNED_EN
      sgn = n_in_signed;
`endif
      n_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (have_hold) begin
        tests_run++;
        if (n_out_valid !== 1'b1 || n_out_p !== held_p || n_out_tag !== held_tag) begin
          tests_failed++;
          $display("FAIL rand_stable_c%0d: valid %0b p %h tag %0d expected 1 %h %0d",
                   cyc, n_out_valid, n_out_p, n_out_tag, held_p, held_tag);
        end
      end
      have_hold = n_out_valid && !n_out_ready;
      held_p    = n_out_p;
      held_tag  = n_out_tag;
      fire_in   = n_in_valid && n_in_ready;
      fire_out  = n_out_valid && n_out_ready;
      if (fire_out) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++; $display("FAIL rand_extra_c%0d: got %h expected no result", cyc, n_out_p);
        end else begin
          e = q.pop_front();
          if (n_out_p !== e.p || n_out_tag !== e.tag) begin
            tests_failed++;
            $display("FAIL rand_result_c%0d: got %h tag %0d expected %h tag %0d",
                     cyc, n_out_p, n_out_tag, e.p, e.tag);
          end
        end
      end
      if (fire_in) begin
        q.push_back('{p: ref_mul8(n_in_a, n_in_b, sgn), tag: n_in_tag});
        sent++;
      end
      hold_in = n_in_valid && !fire_in;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    tests_run++;
    if (sent != 10000 || q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_completion: sent %0d pending %0d expected 10000 and 0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_max_operands();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
`ifdef BOOTH_MUL_SIGNED_EN
    test_signed();
`endif
    test_random8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
